axi_read_burst_ctrl: RTL and testbench
======================================

AXI_READ_BURST_CTRL -- requirements
Module: axi_read_burst_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- AXI4_ADDRESS_WIDTH, 32, AR address width
- AXI4_RDATA_WIDTH, 64, R data and memory word width
- AXI4_ID_WIDTH, 16, ID width
- AXI4_USER_WIDTH, 10, user width
- MEM_ADDR_WIDTH, 13, memory word-address width
- OFFSET_BIT, derived as $clog2(AXI4_RDATA_WIDTH)-3, byte-offset bits
REQ-002 SHALL have one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of clk.
REQ-003 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- ARID_i/ARADDR_i/ARLEN_i/ARBURST_i/ARUSER_i, in, ID/ADDR/8/2/USER, read address channel
- ARVALID_i, in, 1, AR valid
- ARREADY_o, out, 1, AR ready
- RID_o/RDATA_o/RRESP_o/RLAST_o/RUSER_o, out, ID/RDATA/2/1/USER, read data channel
- RVALID_o, out, 1, R valid
- RREADY_i, in, 1, R ready
- MEM_CEN_o, out, 1, memory enable (active low)
- MEM_A_o, out, MEM_ADDR_WIDTH, memory word address
- MEM_Q_i, in, RDATA, memory data, valid the cycle after an issued read
- valid_o, out, 1, memory access request to the arbiter
- grant_i, in, 1, arbiter grant

Function
REQ-004 SHALL use the FSM states IDLE, ISSUE, ERR and DRAIN.
REQ-005 SHALL assert ARREADY_o only in IDLE; an AR handshake captures ID, USER, ARLEN, ARBURST and the word address ARADDR_i[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT], and moves the FSM to ISSUE, or to ERR if the request is rejected.
REQ-006 SHALL reject a request with DECERR when ARADDR_i bits above MEM_ADDR_WIDTH+OFFSET_BIT-1 are nonzero, and with SLVERR when ARBURST==2'b11.
REQ-007 In ISSUE, SHALL assert valid_o and MEM_CEN_o=0 only when FIFO occupancy plus in-flight reads is less than 2.
REQ-008 SHALL count a read as issued when valid_o && grant_i; MEM_Q_i is then written into a 2-entry output FIFO on the next cycle, tagged RRESP=OKAY and RLAST when it is beat ARLEN.
REQ-009 SHALL update the address after each issued read:
- FIXED: unchanged
- INCR: +1 modulo 2^MEM_ADDR_WIDTH
- WRAP: +1 within the aligned block of ARLEN+1 words, wrapping to the block base
REQ-010 SHALL move from ISSUE to DRAIN after issuing beat ARLEN, and from DRAIN to IDLE in the cycle after the RLAST beat handshake.
REQ-011 In ERR, SHALL push ARLEN+1 beats with RDATA=0, the captured RRESP and RLAST on the final beat, with no memory access, then enter DRAIN.
REQ-012 SHALL drive RVALID_o = FIFO non-empty and pop on RVALID_o && RREADY_i; RID_o and RUSER_o equal the captured values throughout the burst.
REQ-013 SHALL allow a push and a pop in the same cycle when the FIFO is full, so that occupancy is unchanged.
REQ-014 SHALL sustain one beat per cycle when RREADY_i and grant_i are held high; first-beat latency is 2 cycles after AR handshake (issue, then FIFO write) and RVALID_o rises in the third cycle.
REQ-015 SHALL, while grant_i is low, hold MEM_A_o stable and keep valid_o asserted.
REQ-016 SHALL hold RDATA_o, RRESP_o and RLAST_o stable while RVALID_o && !RREADY_i.

Reset
REQ-017 On rst, SHALL set the FSM to IDLE, empty the FIFO, and clear the in-flight count and beat counter.
REQ-018 During and after rst, SHALL drive ARREADY_o=0, RVALID_o=0, RLAST_o=0, RRESP_o=0, RDATA_o=0, RID_o=0, RUSER_o=0, valid_o=0, MEM_CEN_o=1 and MEM_A_o=0.
REQ-019 On rst asserted mid-burst, SHALL abandon the burst and discard any MEM_Q_i data returned in the following cycle.

Configuration
REQ-020 SHALL provide the macro AXI_RD_WRAP_BURST_EN:
- Defined: WRAP is supported, and WRAP with ARLEN not in {1,3,7,15} is rejected with SLVERR via ERR.
- Undefined: every WRAP request is rejected with SLVERR via ERR.

Verification
REQ-021 Single read: ARADDR=0x40, ARLEN=0, grant and RREADY held high -> one beat, RDATA=mem[8], RLAST=1, RRESP=0, RVALID high in the third cycle after AR handshake.
REQ-022 INCR back-pressure: ARLEN=7, RREADY toggling 1/0 -> 8 beats of mem[n..n+7] in order, no loss or duplication, at most 2 reads outstanding.
REQ-023 WRAP with macro defined: word address 6, ARLEN=3 -> beats return mem[6], mem[7], mem[4], mem[5]; with macro undefined -> 4 beats, RRESP=2'b10, RDATA=0.
REQ-024 Out-of-range: ARADDR=0x10000 with MEM_ADDR_WIDTH=13, ARLEN=2 -> 3 beats, RRESP=2'b11, MEM_CEN_o stays high throughout.
REQ-025 Grant stall: grant_i low for 5 cycles mid-INCR burst -> MEM_A_o held, valid_o held high, burst completes correctly once grant returns.
REQ-026 Reset mid-burst: rst pulsed during beat 3 of ARLEN=7 -> all outputs at reset values, next AR accepted from IDLE.

Source files
------------

// File: rtl/axi_read_burst_ctrl.sv
// AXI4 read-burst controller: one AR burst at a time, arbitrated single-port memory
// reads, beats returned through a 2-entry R FIFO. Define AXI_RD_WRAP_BURST_EN for WRAP.
module axi_read_burst_ctrl #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_RDATA_WIDTH   = 64,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter int unsigned MEM_ADDR_WIDTH     = 13,
  parameter int unsigned OFFSET_BIT         = $clog2(AXI4_RDATA_WIDTH) - 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                    ARLEN_i,
  input  logic [1:0]                    ARBURST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
  input  logic                          ARVALID_i,
  output logic                          ARREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]      RID_o,
  output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
  output logic [1:0]                    RRESP_o,
  output logic                          RLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
  output logic                          RVALID_o,
  input  logic                          RREADY_i,
  output logic                          MEM_CEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,
  output logic                          valid_o,
  input  logic                          grant_i
);

  localparam int unsigned HI_BIT = MEM_ADDR_WIDTH + OFFSET_BIT;

  typedef enum logic [1:0] {IDLE, ISSUE, ERR, DRAIN} state_e;

  typedef struct packed {
    logic [AXI4_RDATA_WIDTH-1:0] data;
    logic [1:0]                  resp;
    logic                        last;
  } beat_t;

  state_e                      state_q;
  logic [AXI4_ID_WIDTH-1:0]    id_q;
  logic [AXI4_USER_WIDTH-1:0]  user_q;
  logic [7:0]                  len_q;
  logic [1:0]                  burst_q;
  logic [1:0]                  resp_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                  beat_q;
  logic                        pend_q;
  logic                        pend_last_q;
  logic [1:0]                  cnt_q;
  beat_t                       head_q;
  beat_t                       tail_q;

  logic                        ar_hs_c;
  logic                        pop_c;
  logic                        room_c;
  logic                        issue_c;
  logic                        last_beat_c;
  logic                        err_push_c;
  logic                        push_c;
  beat_t                       push_beat_c;
  logic [2:0]                  occ_c;
  logic                        decerr_c;
  logic                        wrap_ok_c;
  logic                        slverr_c;
  logic [MEM_ADDR_WIDTH-1:0]   wrap_mask_c;
  logic [MEM_ADDR_WIDTH-1:0]   addr_d;

  assign ARREADY_o = !rst && (state_q == IDLE);
  assign RVALID_o  = (cnt_q != 2'd0);
  assign RDATA_o   = head_q.data;
  assign RRESP_o   = head_q.resp;
  assign RLAST_o   = head_q.last;
  assign RID_o     = id_q;
  assign RUSER_o   = user_q;
  assign MEM_A_o   = addr_q;

  assign ar_hs_c = ARVALID_i && ARREADY_o;
  assign pop_c   = RVALID_o && RREADY_i;

  // Credit counts the slot freed by a same-cycle pop so a full-rate burst never stalls.
  assign occ_c       = 3'(cnt_q) + 3'(pend_q) - 3'(pop_c);
  assign room_c      = (occ_c < 3'd2);
  assign valid_o     = !rst && (state_q == ISSUE) && room_c;
  assign MEM_CEN_o   = !valid_o;
  assign issue_c     = valid_o && grant_i;
  assign last_beat_c = (beat_q == len_q);
  assign err_push_c  = (state_q == ERR) && room_c;
  assign push_c      = pend_q || err_push_c;

  always_comb begin
    push_beat_c = '{data: '0, resp: resp_q, last: last_beat_c};
    if (pend_q) begin
      push_beat_c = '{data: MEM_Q_i, resp: 2'b00, last: pend_last_q};
    end
  end

  assign decerr_c = ((ARADDR_i >> HI_BIT) != '0);
`ifdef AXI_RD_WRAP_BURST_EN
  assign wrap_ok_c = (ARLEN_i == 8'd1) || (ARLEN_i == 8'd3) ||
                     (ARLEN_i == 8'd7) || (ARLEN_i == 8'd15);
`else
  assign wrap_ok_c = 1'b0;
`endif
  assign slverr_c = (ARBURST_i == 2'b11) || ((ARBURST_i == 2'b10) && !wrap_ok_c);

  // WRAP stays inside the ARLEN+1 aligned block; ARLEN+1 is a power of two there.
  assign wrap_mask_c = MEM_ADDR_WIDTH'(len_q);
  always_comb begin
    addr_d = addr_q;
    case (burst_q)
      2'b01:   addr_d = addr_q + MEM_ADDR_WIDTH'(1);
      2'b10:   addr_d = (addr_q & ~wrap_mask_c) |
                        ((addr_q + MEM_ADDR_WIDTH'(1)) & wrap_mask_c);
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      user_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      resp_q      <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= issue_c;
      pend_last_q <= issue_c && last_beat_c;
      case (state_q)
        IDLE: begin
          if (ar_hs_c) begin
            id_q    <= ARID_i;
            user_q  <= ARUSER_i;
            len_q   <= ARLEN_i;
            burst_q <= ARBURST_i;
            addr_q  <= ARADDR_i[HI_BIT-1:OFFSET_BIT];
            beat_q  <= '0;
            resp_q  <= decerr_c ? 2'b11 : (slverr_c ? 2'b10 : 2'b00);
            state_q <= (decerr_c || slverr_c) ? ERR : ISSUE;
          end
        end
        ISSUE: begin
          if (issue_c) begin
            addr_q <= addr_d;
            beat_q <= beat_q + 8'd1;
            if (last_beat_c) state_q <= DRAIN;
          end
        end
        ERR: begin
          if (err_push_c) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat_c) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_c && RLAST_o) state_q <= IDLE;
        end
      endcase
    end
  end

  // Head entry drives the R channel directly; tail holds the second beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push_c && !pop_c) begin
        cnt_q <= cnt_q + 2'd1;
      end else if (!push_c && pop_c) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (pop_c && (cnt_q == 2'd2)) begin
        head_q <= tail_q;
      end else if (push_c && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop_c))) begin
        head_q <= push_beat_c;
      end
      if (push_c && (((cnt_q == 2'd1) && !pop_c) || (cnt_q == 2'd2))) begin
        tail_q <= push_beat_c;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Directed bench for axi_read_burst_ctrl: a table of bursts plus hand sequences for
// first-beat latency and reset mid-burst. WRAP expectations follow AXI_RD_WRAP_BURST_EN.
module tb_axi_read_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ARID_i;
  logic [31:0] ARADDR_i;
  logic [7:0]  ARLEN_i;
  logic [1:0]  ARBURST_i;
  logic [9:0]  ARUSER_i;
  logic        ARVALID_i;
  logic        ARREADY_o;
  logic [15:0] RID_o;
  logic [63:0] RDATA_o;
  logic [1:0]  RRESP_o;
  logic        RLAST_o;
  logic [9:0]  RUSER_o;
  logic        RVALID_o;
  logic        RREADY_i;
  logic        MEM_CEN_o;
  logic [12:0] MEM_A_o;
  logic [63:0] MEM_Q_i;
  logic        valid_o;
  logic        grant_i;

  int n_cmp = 0;
  int n_bad = 0;

  axi_read_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARBURST_i(ARBURST_i),
    .ARUSER_i(ARUSER_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
    .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
    .RUSER_o(RUSER_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
    .MEM_CEN_o(MEM_CEN_o), .MEM_A_o(MEM_A_o), .MEM_Q_i(MEM_Q_i),
    .valid_o(valid_o), .grant_i(grant_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memval(input logic [15:0] w);
    return {16'hC0DE, w, ~w, 16'h5A5A ^ w};
  endfunction

  // Memory model: data for a granted read appears on the next cycle.
  always @(posedge clk) begin
    if (!MEM_CEN_o && grant_i) MEM_Q_i <= memval(16'(MEM_A_o));
  end

  typedef struct packed {
    logic [31:0]  addr;
    logic [7:0]   len;
    logic [1:0]   burst;
    logic [15:0]  id;
    logic [9:0]   user;
    logic         rr_toggle;
    logic [3:0]   stall;
    logic [1:0]   resp;
    logic [127:0] words;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                              input logic rt, input logic [3:0] st, input logic [1:0] rs,
                              input logic [127:0] w);
    vec_t v;
    v.addr = a; v.len = l; v.burst = b; v.id = 16'h0; v.user = 10'h0;
    v.rr_toggle = rt; v.stall = st; v.resp = rs; v.words = w;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, ".arready"}, 128'(ARREADY_o), 128'(1'b0));
    chk({tag, ".rvalid"},  128'(RVALID_o),  128'(1'b0));
    chk({tag, ".rlast"},   128'(RLAST_o),   128'(1'b0));
    chk({tag, ".rresp"},   128'(RRESP_o),   128'(2'b00));
    chk({tag, ".rdata"},   128'(RDATA_o),   128'(64'h0));
    chk({tag, ".rid"},     128'(RID_o),     128'(16'h0));
    chk({tag, ".ruser"},   128'(RUSER_o),   128'(10'h0));
    chk({tag, ".valid"},   128'(valid_o),   128'(1'b0));
    chk({tag, ".cen"},     128'(MEM_CEN_o), 128'(1'b1));
    chk({tag, ".mem_a"},   128'(MEM_A_o),   128'(13'h0));
  endtask

  // Returns just after the handshake edge with ARVALID dropped.
  task automatic send_ar(input vec_t v, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    ARVALID_i = 1'b1; ARADDR_i = v.addr; ARLEN_i = v.len; ARBURST_i = v.burst;
    ARID_i = v.id; ARUSER_i = v.user;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = ARREADY_o;
      @(posedge clk);
    end
    #1;
    ARVALID_i = 1'b0;
    chk("ar_handshake", 128'(ok), 128'(1'b1));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit ok, done, prev_hold;
    int beats, issued, popped, first_c, last_c, stall_left;
    logic [63:0] pd, exp_d;
    logic [1:0]  pr;
    logic        pl;
    string       p;
    p = $sformatf("v%0d", idx);
    send_ar(v, ok);
    if (!ok) return;
    done = 1'b0; prev_hold = 1'b0;
    beats = 0; issued = 0; popped = 0; first_c = 0; last_c = 0; stall_left = 5;
    pd = '0; pr = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      RREADY_i = v.rr_toggle ? 1'(cyc & 1) : 1'b1;
      grant_i  = !((v.stall != 4'd0) && (issued == int'(v.stall)) && (stall_left > 0));
      #1;
      if (prev_hold) begin
        chk({p, ".hold_valid"}, 128'(RVALID_o), 128'(1'b1));
        chk({p, ".hold_data"},  128'(RDATA_o),  128'(pd));
        chk({p, ".hold_resp"},  128'(RRESP_o),  128'(pr));
        chk({p, ".hold_last"},  128'(RLAST_o),  128'(pl));
      end
      if (!grant_i) begin
        stall_left--;
        chk({p, ".stall_valid"}, 128'(valid_o), 128'(1'b1));
        chk({p, ".stall_addr"},  128'(MEM_A_o), 128'(13'(v.words[16*int'(v.stall) +: 16])));
      end
      if (v.resp != 2'b00) chk({p, ".err_cen"}, 128'(MEM_CEN_o), 128'(1'b1));
      if (valid_o && grant_i) begin
        if (issued < 8)
          chk({p, ".issue_addr"}, 128'(MEM_A_o), 128'(13'(v.words[16*issued +: 16])));
        issued++;
      end
      if (RVALID_o && RREADY_i) begin
        exp_d = (v.resp == 2'b00 && beats < 8) ? memval(v.words[16*beats +: 16]) : 64'h0;
        chk($sformatf("%s.data_b%0d", p, beats), 128'(RDATA_o), 128'(exp_d));
        chk($sformatf("%s.resp_b%0d", p, beats), 128'(RRESP_o), 128'(v.resp));
        chk($sformatf("%s.last_b%0d", p, beats), 128'(RLAST_o), 128'(beats == int'(v.len)));
        chk({p, ".rid"},   128'(RID_o),   128'(v.id));
        chk({p, ".ruser"}, 128'(RUSER_o), 128'(v.user));
        if (beats == 0) first_c = cyc;
        last_c = cyc;
        beats++;
        popped++;
        if (RLAST_o) done = 1'b1;
      end
      chk({p, ".outstanding"}, 128'((issued - popped) <= 2), 128'(1'b1));
      prev_hold = RVALID_o && !RREADY_i;
      pd = RDATA_o; pr = RRESP_o; pl = RLAST_o;
    end
    chk({p, ".completed"}, 128'(done), 128'(1'b1));
    chk({p, ".beats"},  128'(beats),  128'(int'(v.len) + 1));
    chk({p, ".issued"}, 128'(issued), 128'((v.resp == 2'b00) ? int'(v.len) + 1 : 0));
    if (!v.rr_toggle && v.stall == 4'd0)
      chk({p, ".rate"}, 128'(last_c - first_c), 128'(int'(v.len)));
    @(posedge clk);
    #1;
    chk({p, ".back_idle"},  128'(ARREADY_o), 128'(1'b1));
    chk({p, ".no_extra"},   128'(RVALID_o),  128'(1'b0));
    RREADY_i = 1'b1;
    grant_i  = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    bit ok;
    int pops;
    vec_t v;
    vecs[0] = mk(32'h40,    8'd0, 2'b01, 1'b0, 4'd0, 2'b00, 128'(16'd8));
    vecs[1] = mk(32'h100,   8'd7, 2'b01, 1'b1, 4'd0, 2'b00,
                 {16'd39, 16'd38, 16'd37, 16'd36, 16'd35, 16'd34, 16'd33, 16'd32});
`ifdef AXI_RD_WRAP_BURST_EN
    vecs[2] = mk(32'h30,    8'd3, 2'b10, 1'b0, 4'd0, 2'b00,
                 128'({16'd5, 16'd4, 16'd7, 16'd6}));
    vecs[9] = mk(32'h68,    8'd7, 2'b10, 1'b0, 4'd0, 2'b00,
                 {16'd12, 16'd11, 16'd10, 16'd9, 16'd8, 16'd15, 16'd14, 16'd13});
`else
    vecs[2] = mk(32'h30,    8'd3, 2'b10, 1'b0, 4'd0, 2'b10, 128'h0);
    vecs[9] = mk(32'h68,    8'd7, 2'b10, 1'b0, 4'd0, 2'b10, 128'h0);
`endif
    vecs[3] = mk(32'h10000, 8'd2, 2'b01, 1'b0, 4'd0, 2'b11, 128'h0);
    vecs[4] = mk(32'h20,    8'd1, 2'b11, 1'b0, 4'd0, 2'b10, 128'h0);
    vecs[5] = mk(32'h58,    8'd2, 2'b00, 1'b0, 4'd0, 2'b00,
                 128'({16'd11, 16'd11, 16'd11}));
    vecs[6] = mk(32'hFFF0,  8'd3, 2'b01, 1'b0, 4'd0, 2'b00,
                 128'({16'd1, 16'd0, 16'd8191, 16'd8190}));
    vecs[7] = mk(32'h40,    8'd2, 2'b10, 1'b0, 4'd0, 2'b10, 128'h0);
    vecs[8] = mk(32'h140,   8'd7, 2'b01, 1'b0, 4'd3, 2'b00,
                 {16'd47, 16'd46, 16'd45, 16'd44, 16'd43, 16'd42, 16'd41, 16'd40});
    for (int i = 0; i < 10; i++) begin
      vecs[i].id   = 16'hA000 + 16'(i);
      vecs[i].user = 10'(i * 37 + 5);
    end

    rst = 1'b1; ARVALID_i = 1'b0; ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0;
    ARBURST_i = '0; ARUSER_i = '0; RREADY_i = 1'b1; grant_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // First-beat latency of a single read at 0x40.
    v = vecs[0];
    send_ar(v, ok);
    chk("lat.c1_valid",  128'(valid_o),  128'(1'b1));
    chk("lat.c1_addr",   128'(MEM_A_o),  128'(13'd8));
    chk("lat.c1_rvalid", 128'(RVALID_o), 128'(1'b0));
    @(posedge clk); #1;
    chk("lat.c2_rvalid", 128'(RVALID_o), 128'(1'b0));
    @(posedge clk); #1;
    chk("lat.c3_rvalid", 128'(RVALID_o), 128'(1'b1));
    chk("lat.c3_data",   128'(RDATA_o),  128'(memval(16'd8)));
    chk("lat.c3_last",   128'(RLAST_o),  128'(1'b1));
    chk("lat.c3_resp",   128'(RRESP_o),  128'(2'b00));
    @(posedge clk); #1;
    chk("lat.c4_rvalid", 128'(RVALID_o), 128'(1'b0));
    chk("lat.c4_idle",   128'(ARREADY_o), 128'(1'b1));

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset asserted while beat 3 of an 8-beat INCR burst is on the bus.
    v = mk(32'h200, 8'd7, 2'b01, 1'b0, 4'd0, 2'b00, 128'h0);
    v.id = 16'h5555; v.user = 10'h2AA;
    send_ar(v, ok);
    pops = 0;
    for (int i = 0; i < 40 && pops < 3; i++) begin
      @(negedge clk); #1;
      if (RVALID_o && RREADY_i) pops++;
    end
    chk("rst.reach_beat3", 128'(pops), 128'(3));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.during_valid",   128'(valid_o),   128'(1'b0));
    chk("rst.during_cen",     128'(MEM_CEN_o), 128'(1'b1));
    chk("rst.during_arready", 128'(ARREADY_o), 128'(1'b0));
    @(posedge clk); #1;
    check_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst.post_rvalid", 128'(RVALID_o), 128'(1'b0));
    end
    run_vec(10, vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
